// File: rtl/mole_spawner_if.sv
// Signal bundle between the mole spawner and its environment.
// The master side is the game controller/game_logic; the slave side is the spawner.
interface mole_spawner_if;
    logic        enable;
    logic [17:0] ledr_next;
    logic [17:0] ledr_current;
    logic        mole_missed;
    logic [7:0]  miss_count;
    logic [4:0]  active_moles;

    modport master (
        output enable,
        output ledr_next,
        input  ledr_current,
        input  mole_missed,
        input  miss_count,
        input  active_moles
    );

    modport slave (
        input  enable,
        input  ledr_next,
        output ledr_current,
        output mole_missed,
        output miss_count,
        output active_moles
    );
endinterface

// File: rtl/mole_spawner.sv
// Pops moles into pseudo-random holes at a fixed cadence, retires each after a fixed
// lifetime unless game_logic reports it whacked, and counts the ones that escape.
module mole_spawner #(
    parameter int unsigned SPAWN_PERIOD  = 50_000_000,
    parameter int unsigned MOLE_LIFETIME = 75_000_000,
    parameter int unsigned MAX_MOLES     = 3,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic          clk,
    input  logic          reset,
    mole_spawner_if.slave bus
);

    localparam int NUM_HOLES = 18;
    localparam int SCW       = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
    localparam int LW        = $clog2(MOLE_LIFETIME + 1);

    localparam logic [SCW-1:0] SPAWN_LAST = SCW'(SPAWN_PERIOD - 1);
    localparam logic [LW-1:0]  LIFE_INIT  = LW'(MOLE_LIFETIME);
    localparam logic [4:0]     MAX_ACTIVE = 5'(MAX_MOLES);
    localparam logic [15:0]    LFSR_TAPS  = 16'hB400;

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    state_e              state_q, state_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic [SCW-1:0]      spawn_cnt_q, spawn_cnt_d;
    logic [17:0]         ledr_q, ledr_d;
    logic [LW-1:0]       life_q [NUM_HOLES];
    logic [LW-1:0]       life_d [NUM_HOLES];
    logic                missed_q, missed_d;
    logic [7:0]          miss_cnt_q, miss_cnt_d;

    logic [4:0]          active;
    logic [4:0]          cand_raw;
    logic [4:0]          cand;
    logic [17:0]         cand_onehot;
    logic [17:0]         spawn_mask;
    logic [17:0]         expired;
    logic [4:0]          expired_n;
    logic [8:0]          miss_sum;

    function automatic logic [4:0] popcount18(input logic [17:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < NUM_HOLES; i++) begin
            n = n + 5'(v[i]);
        end
        return n;
    endfunction

    assign active = popcount18(ledr_q);

    // Fold the 5-bit LFSR slice onto the 18 holes.
    assign cand_raw    = lfsr_q[4:0];
    assign cand        = (cand_raw >= 5'd18) ? cand_raw - 5'd18 : cand_raw;
    assign cand_onehot = 18'(1) << cand;

    // NOTE: every variable written here gets a default first, so no path can
    // leave one unassigned and infer a latch; all assignments here are blocking.
    always_comb begin
        state_d     = state_q;
        lfsr_d      = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
        spawn_cnt_d = spawn_cnt_q;
        ledr_d      = ledr_q;
        life_d      = life_q;
        missed_d    = 1'b0;
        miss_cnt_d  = miss_cnt_q;
        spawn_mask  = '0;
        expired     = '0;
        expired_n   = '0;
        miss_sum    = '0;

        case (state_q)
            IDLE: begin
                ledr_d      = '0;
                spawn_cnt_d = '0;
                for (int i = 0; i < NUM_HOLES; i++) life_d[i] = '0;
                if (bus.enable) begin
                    state_d    = RUN;
                    miss_cnt_d = '0;
                end
            end

            RUN: begin
                if (!bus.enable) begin
                    state_d     = IDLE;
                    ledr_d      = '0;
                    spawn_cnt_d = '0;
                    for (int i = 0; i < NUM_HOLES; i++) life_d[i] = '0;
                end else begin
                    spawn_cnt_d = (spawn_cnt_q == SPAWN_LAST) ? '0 : spawn_cnt_q + SCW'(1);
                    if (spawn_cnt_q == SPAWN_LAST &&
                        ((ledr_q | bus.ledr_next) & cand_onehot) == '0 &&
                        active < MAX_ACTIVE) begin
                        spawn_mask = cand_onehot;
                    end

                    // A hit takes priority over a same-cycle expiry.
                    for (int i = 0; i < NUM_HOLES; i++) begin
                        life_d[i] = '0;
                        if (ledr_q[i] && bus.ledr_next[i]) begin
                            if (life_q[i] == LW'(1)) begin
                                expired[i] = 1'b1;
                            end else begin
                                life_d[i] = life_q[i] - LW'(1);
                            end
                        end
                        if (spawn_mask[i]) life_d[i] = LIFE_INIT;
                    end

                    // Stray ledr_next bits on dark holes are masked off.
                    ledr_d = (bus.ledr_next & ledr_q & ~expired) | spawn_mask;

                    expired_n  = popcount18(expired);
                    miss_sum   = {1'b0, miss_cnt_q} + 9'(expired_n);
                    miss_cnt_d = (miss_sum > 9'd255) ? 8'd255 : miss_sum[7:0];
                    missed_d   = |expired;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: the lifetime counter array is reset element by element because a
    // stale nonzero count must never survive into a new round.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            lfsr_q      <= LFSR_SEED;
            spawn_cnt_q <= '0;
            ledr_q      <= '0;
            missed_q    <= 1'b0;
            miss_cnt_q  <= '0;
            for (int i = 0; i < NUM_HOLES; i++) life_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            spawn_cnt_q <= spawn_cnt_d;
            ledr_q      <= ledr_d;
            missed_q    <= missed_d;
            miss_cnt_q  <= miss_cnt_d;
            life_q      <= life_d;
        end
    end

    assign bus.ledr_current = ledr_q;
    assign bus.mole_missed  = missed_q;
    assign bus.miss_count   = miss_cnt_q;
    assign bus.active_moles = active;

endmodule

// File: tb/tb_mole_spawner.sv
// Directed bench for mole_spawner with a short spawn period and mole lifetime;
// game_logic is modelled as ledr_next = ledr_current with selectable hits.
module tb_mole_spawner;

    localparam int SP   = 8;
    localparam int LIFE = 20;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk;
    logic        reset;
    logic [17:0] hit_mask;
    logic [17:0] ghost_mask;
    logic [15:0] m_lfsr;
    int          checks;
    int          errors;

    mole_spawner_if bus ();

    assign bus.ledr_next = (bus.ledr_current & ~hit_mask) | ghost_mask;

    mole_spawner #(
        .SPAWN_PERIOD (SP),
        .MOLE_LIFETIME(LIFE),
        .MAX_MOLES    (2),
        .LFSR_SEED    (SEED)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic [15:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ 16'hB400;
        return n;
    endfunction

    function automatic int hole_of(input logic [15:0] s);
        int h;
        h = int'(s[4:0]);
        if (h >= 18) h = h - 18;
        return h;
    endfunction

    // Reference LFSR tracking the DUT's generator edge for edge.
    always @(posedge clk) begin
        if (reset) m_lfsr <= SEED;
        else       m_lfsr <= lfsr_step(m_lfsr);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts a round from IDLE and checks the first spawn lands on the edge
    // SPAWN_PERIOD cycles after the IDLE->RUN edge, in the predicted hole.
    task automatic start_round(output int h);
        bus.enable = 1'b1;
        tick();
        check("round_miss_clear", 32'(bus.miss_count), 0);
        check("pre_dark", 32'(bus.ledr_current), 0);
        for (int k = 1; k < SP; k++) begin
            tick();
            check("pre_dark", 32'(bus.ledr_current), 0);
            check("pre_missed", 32'(bus.mole_missed), 0);
            check("pre_active", 32'(bus.active_moles), 0);
        end
        h = hole_of(m_lfsr);
        tick();
        check("first_spawn", 32'(bus.ledr_current), 32'(1) << h);
        check("first_active", 32'(bus.active_moles), 1);
    endtask

    task automatic wait_two();
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (bus.active_moles == 5'd2) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("two_moles_reached", 32'(ok), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   h;
        int   lit;
        int   max_a;
        logic mono_ok;
        logic any_miss;
        logic [7:0] prev;

        checks     = 0;
        errors     = 0;
        reset      = 1'b1;
        bus.enable = 1'b1;
        hit_mask   = '0;
        ghost_mask = '0;

        // Reset state, reset overriding enable
        repeat (3) tick();
        check("rst_ledr", 32'(bus.ledr_current), 0);
        check("rst_missed", 32'(bus.mole_missed), 0);
        check("rst_miss_count", 32'(bus.miss_count), 0);
        check("rst_active", 32'(bus.active_moles), 0);
        reset = 1'b0;

        // First spawn timing and index
        start_round(h);

        // Unhit mole lives exactly LIFE cycles, then one miss pulse
        lit = 1;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (bus.ledr_current[h]) lit++;
            else break;
        end
        check("lifetime", 32'(lit), LIFE);
        check("miss_pulse", 32'(bus.mole_missed), 1);
        check("miss_count_1", 32'(bus.miss_count), 1);
        tick();
        check("miss_pulse_len", 32'(bus.mole_missed), 0);

        // Concurrency cap
        max_a = 0;
        for (int k = 0; k < 500; k++) begin
            tick();
            if (int'(bus.active_moles) > max_a) max_a = int'(bus.active_moles);
        end
        check("active_le_max", 32'(max_a <= 2), 1);

        // Miss counter saturation without wrap
        mono_ok = 1'b1;
        prev    = bus.miss_count;
        for (int k = 0; k < 9500; k++) begin
            tick();
            if (bus.miss_count < prev) mono_ok = 1'b0;
            prev = bus.miss_count;
        end
        check("miss_monotonic", 32'(mono_ok), 1);
        check("miss_sat", 32'(bus.miss_count), 255);
        repeat (100) tick();
        check("miss_sat_hold", 32'(bus.miss_count), 255);

        // Disable mid-round with two moles lit
        wait_two();
        bus.enable = 1'b0;
        tick();
        check("dis_ledr", 32'(bus.ledr_current), 0);
        check("dis_active", 32'(bus.active_moles), 0);
        check("dis_miss_hold", 32'(bus.miss_count), 255);
        tick();
        check("idle_ledr", 32'(bus.ledr_current), 0);
        start_round(h);

        // Hit on the 5th lit cycle
        repeat (4) tick();
        check("hit5_lit", 32'(bus.ledr_current[h]), 1);
        hit_mask = 18'(1) << h;
        tick();
        check("hit5_clear", 32'(bus.ledr_current[h]), 0);
        check("hit5_no_pulse", 32'(bus.mole_missed), 0);
        hit_mask = '0;
        any_miss = 1'b0;
        repeat (17) begin
            tick();
            if (bus.mole_missed) any_miss = 1'b1;
        end
        check("hit5_no_miss_later", 32'(any_miss), 0);
        check("hit5_miss_count", 32'(bus.miss_count), 0);

        // Hit on the final (20th) lit cycle: hit beats expiry
        bus.enable = 1'b0;
        tick();
        start_round(h);
        repeat (LIFE - 1) tick();
        check("hit20_lit", 32'(bus.ledr_current[h]), 1);
        hit_mask = 18'(1) << h;
        tick();
        check("hit20_clear", 32'(bus.ledr_current[h]), 0);
        check("hit20_no_pulse", 32'(bus.mole_missed), 0);
        check("hit20_miss_count", 32'(bus.miss_count), 0);
        hit_mask = '0;
        tick();
        check("hit20_no_pulse_next", 32'(bus.mole_missed), 0);

        // Reset mid-round with two moles lit
        wait_two();
        reset = 1'b1;
        tick();
        check("mid_rst_ledr", 32'(bus.ledr_current), 0);
        check("mid_rst_miss_count", 32'(bus.miss_count), 0);
        check("mid_rst_missed", 32'(bus.mole_missed), 0);
        reset = 1'b0;
        start_round(h);

        // Stray ledr_next bits on dark holes neither create moles nor allow spawns
        ghost_mask = 18'h3FFFF;
        repeat (40) tick();
        check("ghost_ledr", 32'(bus.ledr_current), 0);
        check("ghost_active", 32'(bus.active_moles), 0);
        check("ghost_miss_count", 32'(bus.miss_count), 1);
        ghost_mask = '0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
